// File: rtl/sr_input_conditioner_if.sv
// Button/command bundle between the raw push-buttons, the conditioner and
// the downstream NOR SR latch. CONFLICT only exists when SR_COND_CONFLICT_EN
// is defined.
//
// Signalling: there is no valid/ready pair. S_IN/R_IN are free-running levels
// sampled every clock. S/R are level pulses of fixed width that the latch
// consumes unconditionally. BUSY marks a pulse or its trailing guard cycle.
// S and R are mutually exclusive.
interface sr_input_conditioner_if;
    logic S_IN;
    logic R_IN;
    logic S;
    logic R;
    logic BUSY;
`ifdef SR_COND_CONFLICT_EN
    logic CONFLICT;

    modport slave  (input S_IN, R_IN, output S, R, BUSY, CONFLICT);
    modport master (output S_IN, R_IN, input S, R, BUSY, CONFLICT);
`else
    modport slave  (input S_IN, R_IN, output S, R, BUSY);
    modport master (output S_IN, R_IN, input S, R, BUSY);
`endif
endinterface

// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner: synchronises and debounces two push-buttons and turns
// their rising edges into single, non-overlapping S/R pulses for a NOR latch.
// Optional feature macro: SR_COND_CONFLICT_EN (simultaneous requests are
// dropped and flagged on CONFLICT instead of being served reset-first).
// Bit 0 of the per-input vectors is the set button, bit 1 the reset button.
module sr_input_conditioner #(
    parameter int DB_CYCLES    = 4,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    sr_input_conditioner_if.slave  bus,
    output logic [1:0]             dbg_state
);

    localparam int DBW = $clog2(DB_CYCLES);
    localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

    logic [1:0]     s1_q, s1_d, s2_q, s2_d;
    logic [1:0]     db_q, db_d;
    logic [DBW-1:0] db_cnt_q [2];
    logic [DBW-1:0] db_cnt_d [2];
    logic [1:0]     req;
    logic [1:0]     pend_q, pend_d, pend_clr;
    state_t         state_q, state_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           s_q, s_d, r_q, r_d, busy_q, busy_d;
    state_t         serve_state;
    logic [1:0]     serve_clr;
`ifdef SR_COND_CONFLICT_EN
    logic           conflict_q, conflict_d, serve_conflict;
`endif

    // Two-flop synchronisers for the asynchronous button inputs.
    always_comb begin
        s1_d = {bus.R_IN, bus.S_IN};
        s2_d = s1_q;
    end

    // Debounce: accept a new level after DB_CYCLES consecutive differing
    // samples; a rising accepted level is a request.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        req = db_d & ~db_q;
    end

    // Arbitration of pending flags when the FSM is free to start a pulse.
    always_comb begin
        serve_state = IDLE;
        serve_clr   = '0;
`ifdef SR_COND_CONFLICT_EN
        serve_conflict = 1'b0;
        if (pend_q == 2'b11) begin
            serve_clr      = 2'b11;
            serve_conflict = 1'b1;
        end else if (pend_q[0]) begin
            serve_state = PULSE_S;
            serve_clr   = 2'b01;
        end else if (pend_q[1]) begin
            serve_state = PULSE_R;
            serve_clr   = 2'b10;
        end
`else
        // Reset wins a tie; the set flag stays pending for later.
        if (pend_q[1]) begin
            serve_state = PULSE_R;
            serve_clr   = 2'b10;
        end else if (pend_q[0]) begin
            serve_state = PULSE_S;
            serve_clr   = 2'b01;
        end
`endif
    end

    // Next-state and registered-output logic. The GAP cycle's exit takes the
    // IDLE decision directly, so back-to-back pulses are one low cycle apart.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = '0;
        pend_clr = '0;
`ifdef SR_COND_CONFLICT_EN
        conflict_d = 1'b0;
`endif
        case (state_q)
            IDLE, GAP: begin
                state_d  = serve_state;
                pend_clr = serve_clr;
`ifdef SR_COND_CONFLICT_EN
                conflict_d = serve_conflict;
`endif
            end
            PULSE_S, PULSE_R: begin
                if (pcnt_q == PULSE_LAST) begin
                    state_d = GAP;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~pend_clr) | req;
        s_d    = (state_d == PULSE_S);
        r_d    = (state_d == PULSE_R);
        busy_d = (state_d != IDLE);
    end

    // State registers; reset cuts any pulse in progress immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            pcnt_q  <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SR_COND_CONFLICT_EN
            conflict_q <= 1'b0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
            pend_q  <= pend_d;
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
`ifdef SR_COND_CONFLICT_EN
            conflict_q <= conflict_d;
`endif
        end
    end

    assign bus.S     = s_q;
    assign bus.R     = r_q;
    assign bus.BUSY  = busy_q;
`ifdef SR_COND_CONFLICT_EN
    assign bus.CONFLICT = conflict_q;
`endif
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Directed bench for sr_input_conditioner (DB_CYCLES=4, PULSE_CYCLES=2).
// Builds with or without SR_COND_CONFLICT_EN.
module tb_sr_input_conditioner;

  localparam int DB  = 4;
  localparam int PW  = 2;
  // Step k ends 1 time unit after rising edge k-1 (edge 0 samples the input);
  // the first pulse cycle is therefore seen at step DB+3.
  localparam int LAT = DB + 3;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  sr_input_conditioner_if bus ();

  sr_input_conditioner #(.DB_CYCLES(DB), .PULSE_CYCLES(PW)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] out_vec();
`ifdef SR_COND_CONFLICT_EN
    return {bus.CONFLICT, bus.S, bus.R, bus.BUSY};
`else
    return {1'b0, bus.S, bus.R, bus.BUSY};
`endif
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  // Run n steps; at each compare {CONFLICT,S,R,BUSY} against the windows.
  task automatic expect_window(input string tag, input int n,
                               input int s_lo, input int s_hi,
                               input int r_lo, input int r_hi,
                               input int b_lo, input int b_hi,
                               input int c_at);
    logic [3:0] e;
    for (int k = 1; k <= n; k++) begin
      step();
      e = {k == c_at, (k >= s_lo) && (k <= s_hi), (k >= r_lo) && (k <= r_hi),
           (k >= b_lo) && (k <= b_hi)};
      check_eq($sformatf("%s_step%0d", tag, k), {28'b0, out_vec()}, {28'b0, e});
    end
  endtask

  // The latch must never see S and R together.
  always @(negedge clk) begin
    if (!rst) check_eq("s_and_r", {31'b0, bus.S & bus.R}, 32'd0);
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.S_IN = 1'b0;
    bus.R_IN = 1'b0;
    settle(3);

    // reset state
    check_eq("rst_outputs", {28'b0, out_vec()}, 32'd0);
    check_eq("rst_state", {30'b0, dbg_state}, 32'd0);
    rst = 1'b0;
    settle(3);
    check_eq("idle_outputs", {28'b0, out_vec()}, 32'd0);

    // set latency: S after edges 6,7; BUSY for 3 cycles
    bus.S_IN = 1'b1;
    expect_window("s_lat", 12, LAT, LAT + 1, 0, -1, LAT, LAT + 2, 0);
    bus.S_IN = 1'b0;
    settle(12);

    // glitch rejection on R
    bus.R_IN = 1'b1; step();
    bus.R_IN = 1'b0; step();
    bus.R_IN = 1'b1; step();
    bus.R_IN = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      check_eq("glitch_r", {31'b0, bus.R}, 32'd0);
      check_eq("glitch_dbr", {31'b0, dut.db_q[1]}, 32'd0);
    end
    bus.R_IN = 1'b1;
    expect_window("r_lat", 12, 0, -1, LAT, LAT + 1, LAT, LAT + 2, 0);
    bus.R_IN = 1'b0;
    settle(12);

    // reset request debounced while S is high
    bus.S_IN = 1'b1;
    step(); step();
    bus.R_IN = 1'b1;
    expect_window("opp", 14, LAT - 2, LAT - 1, LAT + 1, LAT + 2, LAT - 2, LAT + 3, 0);
    bus.S_IN = 1'b0;
    bus.R_IN = 1'b0;
    settle(12);

    // simultaneous press
    bus.S_IN = 1'b1;
    bus.R_IN = 1'b1;
`ifdef SR_COND_CONFLICT_EN
    expect_window("conflict", 12, 0, -1, 0, -1, 0, -1, LAT);
`else
    expect_window("both", 14, LAT + 3, LAT + 4, LAT, LAT + 1, LAT, LAT + 5, 0);
`endif
    bus.S_IN = 1'b0;
    bus.R_IN = 1'b0;
    settle(12);

    // reset mid-pulse, button released during reset: nothing replayed
    bus.S_IN = 1'b1;
    settle(LAT);
    check_eq("pre_rst_s", {31'b0, bus.S}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_out", {28'b0, out_vec()}, 32'd0);
    check_eq("async_rst_state", {30'b0, dbg_state}, 32'd0);
    bus.S_IN = 1'b0;
    step(); step();
    rst = 1'b0;
    expect_window("rst_rel", 14, 0, -1, 0, -1, 0, -1, 0);

    // reset mid-pulse, button held through release: one fresh pulse
    bus.S_IN = 1'b1;
    settle(LAT);
    check_eq("pre_rst2_s", {31'b0, bus.S}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst2_out", {28'b0, out_vec()}, 32'd0);
    step(); step();
    rst = 1'b0;
    expect_window("rst_held", 14, LAT, LAT + 1, 0, -1, LAT, LAT + 2, 0);
    bus.S_IN = 1'b0;
    settle(12);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_input_conditioner.md
# sr_input_conditioner

Synchronous front end that turns two raw, bouncy push-button inputs into clean, single set/reset command pulses for a downstream NOR-type SR latch. Each pulse lasts a programmable number of cycles. The block guarantees that S and R are never high together, so the latch never sees its forbidden input. It sits directly upstream of the latch: its S/R outputs drive the latch's S/R inputs.

## Interface
- `DB_CYCLES`, default 4: consecutive stable samples required to accept a new button level; must be ≥ 2.
- `PULSE_CYCLES`, default 2: width of each S or R pulse, in cycles; must be ≥ 1.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: reset, asynchronous and active-high.
- `S_IN` input 1: raw set button, asynchronous to CLK.
- `R_IN` input 1: raw reset button, asynchronous to CLK.
- `S` output 1: registered set pulse to the latch.
- `R` output 1: registered reset pulse to the latch.
- `BUSY` output 1: high while a pulse or its guard gap is in progress.
- `CONFLICT` output 1: one-cycle flag for a simultaneous request. This port exists only with `SR_COND_CONFLICT_EN`.

## Operation
- **Synchronizer.** Per input, two flip-flops: `sN_1` then `sN_2`.
- **Debounce.** Per input, a counter of width clog2(DB_CYCLES) plus a debounced level `dbN`.
  - When `sN_2` ≠ `dbN`, the counter increments. When it reaches DB_CYCLES−1 while still differing, `dbN` takes the value of `sN_2` and the counter clears.
  - When `sN_2` = `dbN`, the counter clears.
- **Request.** A request is the rising edge of `dbN`, i.e. `dbN` rises while its registered previous value is 0. Falling edges produce nothing.
- **Pending flags.** Each input has a one-deep pending flag, set by a request. Repeat requests for the same input merge into the one flag. A flag clears when its pulse starts.
- **FSM states:** IDLE, PULSE_S, PULSE_R, GAP.
  - IDLE → PULSE_S when only the set flag is pending.
  - IDLE → PULSE_R when only the reset flag is pending.
  - IDLE with both flags pending: resolved by the Configuration rule.
  - PULSE_x lasts PULSE_CYCLES cycles (pulse counter), then → GAP.
  - GAP lasts exactly 1 cycle, then → IDLE. Any flag still pending is served from IDLE on the next cycle.
- **Outputs.** All outputs come from registers, not from combinational logic.
  - S = (state == PULSE_S); R = (state == PULSE_R); BUSY = (state != IDLE).
  - S && R is never true.
- **Requests during a pulse.** A request arriving during PULSE_x or GAP is pended, not dropped. A request for the opposite input is therefore served after the GAP.
- **Reset.**
  - S, R, BUSY and CONFLICT go to 0. State goes to IDLE.
  - Synchronizers, debounced levels, counters and pending flags all go to 0.
  - Reset mid-pulse cuts the pulse immediately. The interrupted command is not replayed.
  - A button held through reset release is seen as a new request once debounced.

## Timing
- **Latency.** Let edge 0 be the first rising edge at which `S_IN` = 1 is sampled, with the input held stable and the block in IDLE. Then:
  - `s_2` = 1 after edge 1.
  - `dbS` = 1 after edge DB_CYCLES+1.
  - S = 1 after edge DB_CYCLES+2 and stays high for PULSE_CYCLES cycles.
  - The same latency applies to R.
- **Glitch rejection.** A bounce shorter than DB_CYCLES cycles at `sN_2` leaves `dbN` unchanged and produces no pulse.
- **Back-to-back.** Minimum spacing between two pulses is one low cycle (GAP).
- **BUSY.** BUSY rises with the pulse and falls one cycle after the pulse ends.

## Configuration
- **`SR_COND_CONFLICT_EN` defined:**
  - Both flags pending in IDLE: both are cleared, no pulse is issued, and the state stays IDLE.
  - CONFLICT pulses high for exactly one cycle.
- **`SR_COND_CONFLICT_EN` undefined:**
  - No CONFLICT port.
  - Both flags pending in IDLE: reset has priority. The FSM goes to PULSE_R, and the set flag stays pending. It is served after the GAP.

## Test plan
- **Reset and latency.** RST high, then low, then `S_IN` = 1 held, with DB_CYCLES=4, PULSE_CYCLES=2 → S high exactly after edges 6 and 7; R stays 0; BUSY high for 3 cycles.
- **Glitch rejection.** `R_IN` bounces 1-0-1-0 with 1-cycle widths, then stays 0 → no R pulse and `dbR` stays 0. Then `R_IN` is held 1 → R pulse at the nominal latency.
- **Opposite request during a pulse.** `R_IN` is debounced while S is high → S pulse completes; 1 low cycle; then a 2-cycle R pulse. S && R is never observed.
- **Simultaneous press, with `SR_COND_CONFLICT_EN`.** `S_IN` and `R_IN` rise on the same edge → CONFLICT high for 1 cycle at edge 6; no S and no R.
- **Simultaneous press, without `SR_COND_CONFLICT_EN`.** Same stimulus → R pulse first, then GAP, then S pulse.
- **Reset mid-pulse.** Assert RST asynchronously while S = 1 → S, BUSY and state clear immediately without waiting for a clock edge. No S pulse after release unless `S_IN` is still held, in which case one S pulse follows at the nominal latency.
